// File: rtl/csa_pkg.sv
// csa_pkg: shared state type, default widths and sizing helpers for the CSA accumulator
package csa_pkg;
  typedef enum logic [1:0] {ACC, RESOLVE, OUTPUT} state_t;
  localparam int IN_W_D = 21;
  localparam int ACC_W_D = 32;
  localparam int CHUNK_W_D = 8;
  localparam int CNT_W_D = 8;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  // Index must also represent n itself, used as the resolve-finished marker.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/csa_3to2_vec.sv
// csa_3to2_vec: bitwise 3:2 compressor, carry output pre-shifted left by one
module csa_3to2_vec #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] co
);
  assign s = a ^ b ^ c;
  assign co = ((a & b) | (a & c) | (b & c)) << 1;
endmodule

// File: rtl/csa_accum_resolve.sv
// csa_accum_resolve: carry-save accumulator with chunked carry-propagate resolve.
// Define CSA_ACC_SIGNED_EN to sign-extend operands; otherwise they are zero-extended.
module csa_accum_resolve
  import csa_pkg::*;
#(
  parameter int IN_W = IN_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int CHUNK_W = CHUNK_W_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);
  localparam int NCHUNK = ceil_div(ACC_W, CHUNK_W);
  localparam int IDX_W = idx_w(NCHUNK);
  localparam int PAD_W = NCHUNK * CHUNK_W;
  state_t state, state_nx;
  logic [ACC_W-1:0] sum, carry, x, s_nx, c_nx;
  logic [PAD_W-1:0] res, s_pad, c_pad;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [CHUNK_W:0] part;
  logic cy, acc_fire, out_fire, done;
`ifdef CSA_ACC_SIGNED_EN
  assign x = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
`else
  assign x = {{(ACC_W-IN_W){1'b0}}, in_data};
`endif
  csa_3to2_vec #(.WIDTH(ACC_W)) u_csa (.a(sum), .b(carry), .c(x), .s(s_nx), .co(c_nx));
  assign in_ready = state == ACC;
  assign out_valid = state == OUTPUT;
  assign acc_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign done = idx == IDX_W'(NCHUNK);
  assign s_pad = PAD_W'(sum);
  assign c_pad = PAD_W'(carry);
  // Bits past ACC_W in the top chunk are zero padding, so its carry-out falls off.
  assign part = (CHUNK_W+1)'(s_pad[idx*CHUNK_W +: CHUNK_W]) + (CHUNK_W+1)'(c_pad[idx*CHUNK_W +: CHUNK_W]) + (CHUNK_W+1)'(cy);
  assign out_data = res[ACC_W-1:0];
  assign out_count = cnt;
  always_comb begin
    state_nx = state;
    case (state)
      ACC:     state_nx = (acc_fire && in_last) ? RESOLVE : ACC;
      RESOLVE: state_nx = done ? OUTPUT : RESOLVE;
      OUTPUT:  state_nx = out_ready ? ACC : OUTPUT;
      default: state_nx = ACC;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? ACC : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      carry <= '0;
      cnt <= '0;
      idx <= '0;
      cy <= 1'b0;
      res <= '0;
    end else begin
      if (acc_fire) begin
        sum <= s_nx;
        carry <= c_nx;
        cnt <= &cnt ? cnt : cnt + 1'b1;
      end
      if (state == RESOLVE && !done) begin
        res[idx*CHUNK_W +: CHUNK_W] <= part[CHUNK_W-1:0];
        cy <= part[CHUNK_W];
        idx <= idx + 1'b1;
      end
      if (state == RESOLVE && done) begin
        idx <= '0;
        cy <= 1'b0;
      end
      if (out_fire) begin
        sum <= '0;
        carry <= '0;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_csa_accum_resolve.sv
// tb_csa_accum_resolve: scoreboard bench over default, ACC_W=24 and CNT_W=2 instances
module tb_csa_accum_resolve;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [20:0] in_data = '0;
  int sel = 0;
  logic v0, v1, v2, r0, r1, r2, o0, o1, o2;
  logic [31:0] d0, d2;
  logic [23:0] d1;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  assign v0 = in_valid && sel == 0;
  assign v1 = in_valid && sel == 1;
  assign v2 = in_valid && sel == 2;
  csa_accum_resolve u0 (.clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(in_data),
    .in_last(in_last), .out_valid(o0), .out_ready(out_ready), .out_data(d0), .out_count(c0));
  csa_accum_resolve #(.ACC_W(24)) u1 (.clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(in_data),
    .in_last(in_last), .out_valid(o1), .out_ready(out_ready), .out_data(d1), .out_count(c1));
  csa_accum_resolve #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(in_data),
    .in_last(in_last), .out_valid(o2), .out_ready(out_ready), .out_data(d2), .out_count(c2));
  logic cur_r, cur_o;
  logic [31:0] cur_d;
  logic [7:0] cur_c;
  always_comb begin
    cur_r = sel == 1 ? r1 : sel == 2 ? r2 : r0;
    cur_o = sel == 1 ? o1 : sel == 2 ? o2 : o0;
    cur_d = sel == 1 ? {8'b0, d1} : sel == 2 ? d2 : d0;
    cur_c = sel == 1 ? c1 : sel == 2 ? {6'b0, c2} : c0;
  end
  typedef struct {logic [31:0] d; logic [7:0] c;} exp_t;
  exp_t sb[$];
  logic [20:0] pkt[$];
  int checks = 0, errors = 0, cyc = 0, last_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic send(input bit push);
    logic [63:0] acc = '0;
    logic [63:0] ext;
    int n = pkt.size();
    int cmax = sel == 2 ? 3 : 255;
    exp_t e;
    foreach (pkt[i]) begin
`ifdef CSA_ACC_SIGNED_EN
      ext = {{43{pkt[i][20]}}, pkt[i]};
`else
      ext = {43'b0, pkt[i]};
`endif
      acc = acc + ext;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = pkt[i];
      in_last = (i == n - 1);
      @(posedge clk);
      #1;
    end
    last_cyc = cyc;
    in_valid = 1'b0;
    in_last = 1'b0;
    e.d = sel == 1 ? {8'b0, acc[23:0]} : acc[31:0];
    e.c = 8'(n > cmax ? cmax : n);
    if (push) sb.push_back(e);
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!cur_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = cur_o;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL out_valid_timeout sel=%0d got out_valid=%b want 1", sel, cur_o);
    end
  endtask

  task automatic collect(input int lat);
    bit ok;
    exp_t e;
    wait_valid(ok);
    if (!ok) return;
    if (lat > 0) begin
      checks++;
      if (cyc - last_cyc !== lat) begin
        errors++;
        $display("FAIL latency sel=%0d got %0d want %0d", sel, cyc - last_cyc, lat);
      end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty sel=%0d got result %0d want none", sel, cur_d);
      return;
    end
    e = sb.pop_front();
    if (cur_d !== e.d) begin
      errors++;
      $display("FAIL out_data sel=%0d got %0d want %0d", sel, cur_d, e.d);
    end
    checks++;
    if (cur_c !== e.c) begin
      errors++;
      $display("FAIL out_count sel=%0d got %0d want %0d", sel, cur_c, e.c);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (cur_r !== 1'b1 || cur_o !== 1'b0) begin
      errors++;
      $display("FAIL post_handshake sel=%0d got ready=%b valid=%b want 1 0", sel, cur_r, cur_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (r0 !== 1'b1 || r1 !== 1'b1 || r2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b%b%b want 111", r0, r1, r2);
    end
    checks++;
    if (o0 !== 1'b0 || o1 !== 1'b0 || o2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b%b%b want 000", o0, o1, o2);
    end
    checks++;
    if (d0 !== 32'd0 || c0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got data=%0d count=%0d want 0 0", d0, c0);
    end
  endtask

  task automatic test_basic;
    sel = 0;
    pkt = '{21'd5, 21'd7, 21'd9};
    send(1);
    collect(5);
  endtask

  task automatic test_wrap24;
    sel = 1;
    pkt = {};
    repeat (9) pkt.push_back(21'h1FFFFF);
    send(1);
    collect(4);
  endtask

  task automatic test_sign;
    sel = 0;
    pkt = '{21'h1FFFFF, 21'd3};
    send(1);
    collect(5);
  endtask

  task automatic test_backpressure;
    bit ok;
    sel = 0;
    pkt = '{21'd10, 21'd20};
    send(1);
    wait_valid(ok);
    if (!ok) return;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data = 21'(i + 1);
      in_last = 1'b1;
      @(negedge clk);
      checks++;
      if (cur_o !== 1'b1 || cur_r !== 1'b0) begin
        errors++;
        $display("FAIL bp_handshake cyc=%0d got valid=%b ready=%b want 1 0", i, cur_o, cur_r);
      end
      checks++;
      if (cur_d !== sb[0].d || cur_c !== sb[0].c) begin
        errors++;
        $display("FAIL bp_stable cyc=%0d got %0d/%0d want %0d/%0d", i, cur_d, cur_c, sb[0].d, sb[0].c);
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    collect(0);
    pkt = '{21'd4};
    send(1);
    collect(5);
  endtask

  task automatic test_reset_mid;
    sel = 0;
    pkt = '{21'd100, 21'd200};
    send(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cur_o !== 1'b0 || cur_r !== 1'b1 || cur_c !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b ready=%b count=%0d want 0 1 0", cur_o, cur_r, cur_c);
    end
    pkt = '{21'd4};
    send(1);
    collect(5);
  endtask

  task automatic test_saturate;
    sel = 2;
    pkt = '{21'd1, 21'd1, 21'd1, 21'd1, 21'd1};
    send(1);
    collect(5);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap24;
    test_sign;
    test_backpressure;
    test_reset_mid;
    test_saturate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog");
  end
endmodule
